// File: rtl/rom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_pkg
//  Description : Shared types and constants for the ROM port arbiter:
//                FSM state encoding, SDRAM address width, default client
//                bases and the round-robin grant helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_pkg;

    // Arbiter FSM states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // SDRAM word-address width
    localparam int SDR_AW = 25;

    // Default SDRAM word-address bases of the two clients
    localparam logic [SDR_AW-1:0] P0_BASE_DEFAULT = 25'h0000000;
    localparam logic [SDR_AW-1:0] P1_BASE_DEFAULT = 25'h0040000;

    // Grant decision: returns 1 to grant client 1, 0 to grant client 0.
    // On a tie the client that was not granted last wins.
    function automatic logic rr_pick(input logic elig0,
                                     input logic elig1,
                                     input logic last_gnt);
        logic pick1;
        if (elig0 && elig1) begin
            pick1 = ~last_gnt;
        end else begin
            pick1 = elig1;
        end
        return pick1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rom_port_arb
//  Description : Round-robin arbiter giving the 68k program-ROM cache miss
//                port (client 0, 16-bit words) and the Z80 sound-ROM fetch
//                port (client 1, bytes) single-word reads on one SDRAM read
//                channel. Requests and valids are level-held handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arb
    import rom_pkg::*;
#(
    parameter logic [SDR_AW-1:0] P0_BASE = P0_BASE_DEFAULT,
    parameter logic [SDR_AW-1:0] P1_BASE = P1_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic [16:0]       p0_addr,
    output logic [15:0]       p0_data,
    output logic              p0_valid,

    input  logic              p1_req,
    input  logic [15:0]       p1_addr,
    output logic [7:0]        p1_data,
    output logic              p1_valid,

    output logic              sdr_req,
    output logic [SDR_AW-1:0] sdr_addr,
    input  logic              sdr_rdy,
    input  logic [15:0]       sdr_dout
);

    arb_state_t        state_q;
    logic              gnt_q;        // client owning the current read
    logic              last_gnt_q;   // client that completed the previous read
    logic              byte_sel_q;   // client 1 byte lane: 1 = low byte
    logic              drop_q;       // owner withdrew its request mid-read
    logic              served0_q;
    logic              served1_q;
    logic [15:0]       p0_data_q;
    logic              p0_valid_q;
    logic [7:0]        p1_data_q;
    logic              p1_valid_q;
    logic              sdr_req_q;
    logic [SDR_AW-1:0] sdr_addr_q;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_pick1;
    logic              w_gnt_req;

    // A client may be granted only once per request; it must drop req first
    assign w_elig0   = p0_req & ~served0_q;
    assign w_elig1   = p1_req & ~served1_q;
    assign w_pick1   = rr_pick(w_elig0, w_elig1, last_gnt_q);
    assign w_gnt_req = gnt_q ? p1_req : p0_req;

    assign p0_data   = p0_data_q;
    assign p0_valid  = p0_valid_q;
    assign p1_data   = p1_data_q;
    assign p1_valid  = p1_valid_q;
    assign sdr_req   = sdr_req_q;
    assign sdr_addr  = sdr_addr_q;

    // Arbiter FSM together with all registered outputs and handshake flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            byte_sel_q <= 1'b0;
            drop_q     <= 1'b0;
            served0_q  <= 1'b0;
            served1_q  <= 1'b0;
            p0_data_q  <= '0;
            p0_valid_q <= 1'b0;
            p1_data_q  <= '0;
            p1_valid_q <= 1'b0;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
        end else begin
            // Handshake completes once the owner is seen with req low;
            // data registers keep their last value.
            if (!p0_req) begin
                p0_valid_q <= 1'b0;
                served0_q  <= 1'b0;
            end
            if (!p1_req) begin
                p1_valid_q <= 1'b0;
                served1_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_elig0 || w_elig1) begin
                        gnt_q      <= w_pick1;
                        drop_q     <= 1'b0;
                        byte_sel_q <= p1_addr[0];
                        // sdr_req is registered here so it is already high
                        // while the FSM sits in ISSUE.
                        sdr_req_q  <= 1'b1;
                        if (w_pick1) begin
                            sdr_addr_q <= P1_BASE + {{(SDR_AW-15){1'b0}}, p1_addr[15:1]};
                        end else begin
                            sdr_addr_q <= P0_BASE + {{(SDR_AW-17){1'b0}}, p0_addr};
                        end
                        state_q    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!w_gnt_req) begin
                        drop_q <= 1'b1;
                    end
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (sdr_rdy) begin
                        sdr_req_q  <= 1'b0;
                        last_gnt_q <= gnt_q;
                        state_q    <= ST_DONE;
                        // A withdrawn request still finishes on the SDRAM
                        // side, but its data is thrown away.
                        if (w_gnt_req && !drop_q) begin
                            if (gnt_q) begin
                                p1_data_q  <= byte_sel_q ? sdr_dout[7:0] : sdr_dout[15:8];
                                p1_valid_q <= 1'b1;
                                served1_q  <= 1'b1;
                            end else begin
                                p0_data_q  <= sdr_dout;
                                p0_valid_q <= 1'b1;
                                served0_q  <= 1'b1;
                            end
                        end
                    end else if (!w_gnt_req) begin
                        drop_q <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_port_arb
//  Description : Self-checking bench for rom_port_arb: randomized client
//                traffic against a transaction-level model with an SDRAM
//                responder, plus directed byte-select, withdraw, async-reset
//                and address-wrap scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_port_arb;
    import rom_pkg::*;

    localparam logic [24:0] C_P0_BASE   = 25'h0000000;
    localparam logic [24:0] C_P1_BASE   = 25'h0040000;
    localparam logic [24:0] C_WRAP_BASE = 25'h1FFFFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req;
    logic [16:0] p0_addr;
    logic [15:0] p0_data;
    logic        p0_valid;
    logic        p1_req;
    logic [15:0] p1_addr;
    logic [7:0]  p1_data;
    logic        p1_valid;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic        sdr_rdy;
    logic [15:0] sdr_dout;

    logic        w_p0_req;
    logic [16:0] w_p0_addr;
    logic [15:0] w_p0_data;
    logic        w_p0_valid;
    logic        w_p1_req;
    logic [15:0] w_p1_addr;
    logic [7:0]  w_p1_data;
    logic        w_p1_valid;
    logic        w_sdr_req;
    logic [24:0] w_sdr_addr;
    logic        w_sdr_rdy;
    logic [15:0] w_sdr_dout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_port_arb #(.P0_BASE(C_P0_BASE), .P1_BASE(C_P1_BASE)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_data(p0_data), .p0_valid(p0_valid),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_data(p1_data), .p1_valid(p1_valid),
        .sdr_req(sdr_req), .sdr_addr(sdr_addr), .sdr_rdy(sdr_rdy), .sdr_dout(sdr_dout)
    );

    rom_port_arb #(.P0_BASE(C_WRAP_BASE), .P1_BASE(C_P1_BASE)) u_wrap (
        .clk(clk), .reset_n(reset_n),
        .p0_req(w_p0_req), .p0_addr(w_p0_addr), .p0_data(w_p0_data), .p0_valid(w_p0_valid),
        .p1_req(w_p1_req), .p1_addr(w_p1_addr), .p1_data(w_p1_data), .p1_valid(w_p1_valid),
        .sdr_req(w_sdr_req), .sdr_addr(w_sdr_addr), .sdr_rdy(w_sdr_rdy), .sdr_dout(w_sdr_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- SDRAM memory + responder model ----------------
    int          lat      = 3;
    bit          rsp_pend = 1'b0;
    int          rsp_cnt  = 0;
    logic [24:0] rsp_addr = '0;
    int          rdy_cyc  = 0;
    bit          stray    = 1'b0;
    bit          frc_en   = 1'b0;
    logic [15:0] frc_dout = '0;
    logic [15:0] salt     = '0;

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        if (frc_en) return frc_dout;
        return a[15:0] ^ {a[24:16], a[6:0]} ^ salt;
    endfunction

    initial begin
        sdr_rdy  = 1'b0;
        sdr_dout = '0;
        forever begin
            @(negedge clk);
            sdr_rdy = 1'b0;
            if (rsp_pend) begin
                if (rsp_cnt == 1) begin
                    if (!stray) begin
                        chk("addr_stable", 32'(sdr_addr), 32'(rsp_addr));
                        chk("req_held", 32'(sdr_req), 32'd1);
                    end
                    stray    = 1'b0;
                    sdr_rdy  = 1'b1;
                    sdr_dout = mem_word(rsp_addr);
                    rsp_pend = 1'b0;
                    rdy_cyc  = cyc;
                end else begin
                    rsp_cnt--;
                end
            end else if (sdr_req && reset_n) begin
                rsp_pend = 1'b1;
                rsp_cnt  = lat;
                rsp_addr = sdr_addr;
            end
        end
    end

    // ---------------- transaction-level reference ----------------
    int model_last = 1;   // client that completed the last read

    function automatic logic sig(input int which);
        case (which)
            0:       return sdr_req;
            1:       return p0_valid;
            default: return p1_valid;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            ok = sig(which);
        end
    endtask

    // Raise the selected requests together and follow every expected grant
    task automatic run_round(input bit r0, input bit r1, input logic [16:0] a0,
                             input logic [15:0] a1, input int l);
        int          order[$];
        int          g;
        int          n;
        int          hold;
        logic        ok;
        logic [24:0] ea;
        logic [15:0] w;
        logic [15:0] ed;
        lat = l;
        if (r0 && r1) begin
            if (model_last == 1) order = '{0, 1};
            else                 order = '{1, 0};
        end else if (r0) begin
            order = '{0};
        end else begin
            order = '{1};
        end
        p0_addr = a0;
        p1_addr = a1;
        p0_req  = r0;
        p1_req  = r1;
        foreach (order[k]) begin
            g = order[k];
            wait_for(0, 40, n, ok);
            chk("sdr_req_seen", 32'(ok), 32'd1);
            if (k == 0) chk("req_latency", 32'(n), 32'd1);
            else        chk("b2b_gap_ok", 32'((cyc - rdy_cyc) >= 2 && (cyc - rdy_cyc) <= 3), 32'd1);
            ea = (g == 1) ? C_P1_BASE + 25'(a1[15:1]) : C_P0_BASE + 25'(a0);
            chk(g == 1 ? "sdr_addr_p1" : "sdr_addr_p0", 32'(sdr_addr), 32'(ea));
            wait_for(1 + g, 40, n, ok);
            chk("valid_seen", 32'(ok), 32'd1);
            if (k == 0) chk("valid_latency", 32'(n), 32'(l + 1));
            w  = mem_word(ea);
            ed = (g == 1) ? (a1[0] ? {8'd0, w[7:0]} : {8'd0, w[15:8]}) : w;
            if (g == 1) chk("p1_data", 32'(p1_data), 32'(ed));
            else        chk("p0_data", 32'(p0_data), 32'(ed));
            chk("other_valid_low", 32'(g == 1 ? p0_valid : p1_valid), 32'd0);
            model_last = g;
            hold = (k == order.size() - 1) ? $urandom_range(1, 3) : 0;
            repeat (hold) begin
                @(negedge clk);
                chk("valid_held", 32'(sig(1 + g)), 32'd1);
            end
            if (g == 1) p1_req = 1'b0;
            else        p0_req = 1'b0;
            @(negedge clk);
            chk("valid_cleared", 32'(sig(1 + g)), 32'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        logic        ok;
        bit          seen;
        int          sel;
        logic [16:0] wa[2];
        logic [24:0] we[2];

        reset_n   = 1'b0;
        p0_req    = 1'b0; p0_addr   = '0;
        p1_req    = 1'b0; p1_addr   = '0;
        w_p0_req  = 1'b0; w_p0_addr = '0;
        w_p1_req  = 1'b0; w_p1_addr = '0;
        w_sdr_rdy = 1'b0; w_sdr_dout = '0;
        salt      = 16'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_sdr_req",  32'(sdr_req),  32'd0);
        chk("rst_sdr_addr", 32'(sdr_addr), 32'd0);
        chk("rst_p0_valid", 32'(p0_valid), 32'd0);
        chk("rst_p1_valid", 32'(p1_valid), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: single word read, then both byte lanes
        frc_en = 1'b1;
        frc_dout = 16'hBEEF;
        run_round(1'b1, 1'b0, 17'h00123, 16'h0000, 4);
        frc_dout = 16'hA55A;
        run_round(1'b0, 1'b1, 17'h00000, 16'h0011, 3);
        run_round(1'b0, 1'b1, 17'h00000, 16'h0010, 2);
        frc_en = 1'b0;

        // Directed: simultaneous requests, twice so the tie order is exercised
        run_round(1'b1, 1'b1, 17'h1ABCD, 16'hFFFF, 3);
        run_round(1'b1, 1'b1, 17'h00042, 16'h1234, 1);

        // Request withdrawn while waiting for the SDRAM
        lat = 6;
        p0_addr = 17'h0BEEF;
        p0_req  = 1'b1;
        wait_for(0, 40, n, ok);
        chk("wd_sdr_req_seen", 32'(ok), 32'd1);
        @(negedge clk);
        p0_req = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (p0_valid) seen = 1'b1;
        end
        chk("wd_no_valid", 32'(seen), 32'd0);
        chk("wd_sdr_req_low", 32'(sdr_req), 32'd0);
        model_last = 0;
        run_round(1'b1, 1'b1, 17'h00777, 16'h4321, 2);

        // Async reset in the middle of a read
        lat = 8;
        p0_addr = 17'h00055;
        p0_req  = 1'b1;
        wait_for(0, 40, n, ok);
        chk("rs_sdr_req_seen", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        stray   = 1'b1;
        p0_req  = 1'b0;
        #1;
        chk("rs_sdr_req",  32'(sdr_req),  32'd0);
        chk("rs_sdr_addr", 32'(sdr_addr), 32'd0);
        chk("rs_p0_data",  32'(p0_data),  32'd0);
        chk("rs_p1_data",  32'(p1_data),  32'd0);
        chk("rs_p0_valid", 32'(p0_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_last = 1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (p0_valid || p1_valid || sdr_req) seen = 1'b1;
        end
        chk("rs_stray_ignored", 32'(seen), 32'd0);
        run_round(1'b1, 1'b1, 17'h00900, 16'h00A1, 3);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            run_round(sel[0], sel[1], 17'($urandom), 16'($urandom), $urandom_range(1, 6));
        end

        // Address wrap on the second instance
        wa[0] = 17'h00001; we[0] = 25'h0000000;
        wa[1] = 17'h1FFFF; we[1] = 25'h001FFFE;
        for (int i = 0; i < 2; i++) begin
            w_p0_addr = wa[i];
            w_p0_req  = 1'b1;
            @(negedge clk);
            chk("wrap_sdr_req",  32'(w_sdr_req),  32'd1);
            chk("wrap_sdr_addr", 32'(w_sdr_addr), 32'(we[i]));
            @(negedge clk);
            w_sdr_dout = 16'h1234 + 16'(i);
            w_sdr_rdy  = 1'b1;
            @(negedge clk);
            w_sdr_rdy  = 1'b0;
            chk("wrap_valid", 32'(w_p0_valid), 32'd1);
            chk("wrap_data",  32'(w_p0_data),  32'(16'h1234 + 16'(i)));
            chk("wrap_p1_idle", 32'(w_p1_valid), 32'd0);
            w_p0_req = 1'b0;
            @(negedge clk);
            chk("wrap_valid_clr", 32'(w_p0_valid), 32'd0);
            @(negedge clk);
        end
        chk("wrap_p1_data", 32'(w_p1_data), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
